// File: rtl/dp_sram_ctrl.sv
// True dual-port word-addressed SRAM with byte write enables, selectable read latency,
// a post-reset clear sequencer and deterministic same-address dual-write arbitration.
module dp_sram_ctrl #(
    parameter int              AW       = 13,
    parameter int              DW       = 32,
    parameter int              RD_LAT   = 1,
    parameter int              COLL_POL = 0,
    parameter int              INIT_EN  = 1,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [DW/8-1:0]   a_be,
    input  logic [AW-1:0]     a_addr,
    input  logic [DW-1:0]     a_wdata,
    output logic [DW-1:0]     a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [DW/8-1:0]   b_be,
    input  logic [AW-1:0]     b_addr,
    input  logic [DW-1:0]     b_wdata,
    output logic [DW-1:0]     b_rdata,
    output logic              b_rvalid,
    output logic              init_busy,
    output logic              coll_pulse,
    output logic [15:0]       coll_cnt
);
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t              state;
    logic [AW-1:0]       init_addr;
    logic [DW-1:0]       mem [DEPTH];

    logic                ready;
    logic                init_wr;
    logic                a_wr, a_rd, b_wr, b_rd;
    logic                coll;
    logic [NB-1:0]       a_mask, b_mask;

    // Requests arriving on a reset edge are dropped so the array is untouched by reset.
    assign ready   = (state == S_READY) && !rst;
    assign init_wr = (state == S_INIT) && !rst;
    assign a_wr    = ready && a_en && a_we;
    assign a_rd    = ready && a_en && !a_we;
    assign b_wr    = ready && b_en && b_we;
    assign b_rd    = ready && b_en && !b_we;
    assign coll    = a_wr && b_wr && (a_addr == b_addr);

    always_comb begin
        a_mask = a_wr ? a_be : '0;
        b_mask = b_wr ? b_be : '0;
        if (coll) begin
            if (COLL_POL == 0) begin
                b_mask = b_mask & ~a_mask;
            end else begin
                a_mask = a_mask & ~b_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (INIT_EN != 0) ? S_INIT : S_READY;
            init_addr <= '0;
            init_busy <= (INIT_EN != 0);
        end else if (state == S_INIT) begin
            init_addr <= init_addr + 1'b1;
            if (init_addr == '1) begin
                state     <= S_READY;
                init_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem[init_addr] <= INIT_VAL;
        end
        for (int i = 0; i < NB; i++) begin
            if (a_mask[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
            if (b_mask[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
        end
    end

    logic [DW-1:0] a_src, b_src;
    logic          a_src_vld, b_src_vld;

    // Stage p0: array read (read-first), only present for two-cycle latency
    if (RD_LAT == 2) begin : g_lat2
        logic [DW-1:0] a_data_p0, b_data_p0;
        logic          a_vld_p0, b_vld_p0;

        always_ff @(posedge clk) begin
            if (a_rd) a_data_p0 <= mem[a_addr];
            if (b_rd) b_data_p0 <= mem[b_addr];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                a_vld_p0 <= 1'b0;
                b_vld_p0 <= 1'b0;
            end else begin
                a_vld_p0 <= a_rd;
                b_vld_p0 <= b_rd;
            end
        end

        assign a_src     = a_data_p0;
        assign b_src     = b_data_p0;
        assign a_src_vld = a_vld_p0;
        assign b_src_vld = b_vld_p0;
    end else begin : g_lat1
        assign a_src     = mem[a_addr];
        assign b_src     = mem[b_addr];
        assign a_src_vld = a_rd;
        assign b_src_vld = b_rd;
    end

    // Stage p1: output register, data held while no read completes
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata  <= '0;
            b_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_src_vld;
            b_rvalid <= b_src_vld;
            if (a_src_vld) a_rdata <= a_src;
            if (b_src_vld) b_rdata <= b_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_pulse <= 1'b0;
            coll_cnt   <= '0;
        end else begin
            coll_pulse <= coll;
            if (coll && (coll_cnt != 16'hFFFF)) begin
                coll_cnt <= coll_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dp_sram_ctrl.sv
// Scoreboard bench: one stimulus stream drives a 1-cycle and a 2-cycle latency instance,
// a behavioural memory model predicts read data, latency, init and collision outputs.
module tb_dp_sram_ctrl;
    localparam int          AW   = 4;
    localparam int          DW   = 32;
    localparam logic [31:0] IVAL = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, a_we, b_en, b_we;
    logic [3:0]  a_be, b_be;
    logic [3:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    logic [31:0] a_rdata1, b_rdata1, a_rdata2, b_rdata2;
    logic        a_rvalid1, b_rvalid1, a_rvalid2, b_rvalid2;
    logic        busy1, busy2, pulse1, pulse2;
    logic [15:0] cnt1, cnt2;

    always #5 clk = ~clk;

    dp_sram_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1), .COLL_POL(0), .INIT_EN(1), .INIT_VAL(IVAL)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
        .init_busy(busy1), .coll_pulse(pulse1), .coll_cnt(cnt1)
    );

    dp_sram_ctrl #(.AW(AW), .DW(DW), .RD_LAT(2), .COLL_POL(0), .INIT_EN(1), .INIT_VAL(IVAL)) u_dut2 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata2), .a_rvalid(a_rvalid2),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata2), .b_rvalid(b_rvalid2),
        .init_busy(busy2), .coll_pulse(pulse2), .coll_cnt(cnt2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model state; sb index 0/1 = lat1 A/B, 2/3 = lat2 A/B; entry = {due_cycle, data}
    int          cyc    = 0;
    logic [31:0] m_mem [16];
    logic        m_busy = 1'b1;
    int          m_icnt = 0;
    logic        m_pulse = 1'b0;
    logic [15:0] m_cnt  = 16'd0;
    logic [63:0] sb [4][$];

    always @(posedge clk) begin
        logic wa, wb;
        cyc++;
        if (rst) begin
            m_busy  = 1'b1;
            m_icnt  = 0;
            m_pulse = 1'b0;
            m_cnt   = 16'd0;
            for (int i = 0; i < 4; i++) begin
                while (sb[i].size() > 0 && int'(sb[i][$][63:32]) >= cyc) void'(sb[i].pop_back());
            end
        end else if (m_busy) begin
            m_mem[m_icnt] = IVAL;
            m_icnt++;
            if (m_icnt == 16) m_busy = 1'b0;
            m_pulse = 1'b0;
        end else begin
            if (a_en && !a_we) begin
                sb[0].push_back({32'(cyc), m_mem[a_addr]});
                sb[2].push_back({32'(cyc + 1), m_mem[a_addr]});
            end
            if (b_en && !b_we) begin
                sb[1].push_back({32'(cyc), m_mem[b_addr]});
                sb[3].push_back({32'(cyc + 1), m_mem[b_addr]});
            end
            wa = a_en && a_we;
            wb = b_en && b_we;
            // B applied first so A (the collision winner) overrides shared lanes
            if (wb) for (int k = 0; k < 4; k++) if (b_be[k]) m_mem[b_addr][k*8 +: 8] = b_wdata[k*8 +: 8];
            if (wa) for (int k = 0; k < 4; k++) if (a_be[k]) m_mem[a_addr][k*8 +: 8] = a_wdata[k*8 +: 8];
            m_pulse = wa && wb && (a_addr == b_addr);
            if (m_pulse && m_cnt != 16'hFFFF) m_cnt++;
        end
    end

    task automatic mon(input int idx, input logic vld, input logic [31:0] data, input string tag);
        logic [63:0] e;
        if (vld) begin
            if (sb[idx].size() == 0) begin
                chk_val({tag, "_spurious_rvalid"}, 32'(vld), 32'd0);
            end else begin
                e = sb[idx].pop_front();
                chk_val({tag, "_rdata"}, data, e[31:0]);
                chk_val({tag, "_latency"}, 32'(cyc), e[63:32]);
            end
        end else if (sb[idx].size() > 0 && int'(sb[idx][0][63:32]) <= cyc) begin
            e = sb[idx].pop_front();
            chk_val({tag, "_missing_rvalid"}, 32'(vld), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            mon(0, a_rvalid1, a_rdata1, "lat1_A");
            mon(1, b_rvalid1, b_rdata1, "lat1_B");
            mon(2, a_rvalid2, a_rdata2, "lat2_A");
            mon(3, b_rvalid2, b_rdata2, "lat2_B");
            chk_val("init_busy1", 32'(busy1), 32'(m_busy));
            chk_val("init_busy2", 32'(busy2), 32'(m_busy));
            chk_val("coll_pulse1", 32'(pulse1), 32'(m_pulse));
            chk_val("coll_pulse2", 32'(pulse2), 32'(m_pulse));
            chk_val("coll_cnt1", 32'(cnt1), 32'(m_cnt));
            chk_val("coll_cnt2", 32'(cnt2), 32'(m_cnt));
        end
    end

    task automatic drive(input logic ae, input logic awe, input logic [3:0] abe, input logic [3:0] aad,
                         input logic [31:0] awd, input logic be_, input logic bwe, input logic [3:0] bbe,
                         input logic [3:0] bad, input logic [31:0] bwd);
        a_en = ae; a_we = awe; a_be = abe; a_addr = aad; a_wdata = awd;
        b_en = be_; b_we = bwe; b_be = bbe; b_addr = bad; b_wdata = bwd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (busy1 !== 1'b0 && k < 100) begin
            idle(1);
            k++;
        end
        chk_val("init_done_in_budget", 32'(busy1), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        wait_ready();

        // Whole array reads back the init word
        for (int i = 0; i < 16; i++) drive(1, 0, 4'h0, 4'(i), 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);

        // Write on A then read on B
        drive(1, 1, 4'hF, 4'd1, 32'h11111111, 0, 0, 4'h0, 4'h0, 32'h0);
        drive(0, 0, 4'h0, 4'd0, 32'h0, 1, 0, 4'h0, 4'd1, 32'h0);

        // Read-first on a same-cycle write/read pair
        drive(1, 1, 4'hF, 4'd5, 32'h11111111, 0, 0, 4'h0, 4'h0, 32'h0);
        drive(1, 1, 4'hF, 4'd5, 32'h22222222, 1, 0, 4'h0, 4'd5, 32'h0);
        drive(0, 0, 4'h0, 4'd0, 32'h0, 1, 0, 4'h0, 4'd5, 32'h0);

        // Collisions: full overlap, disjoint lanes, be=0, then non-collision pairs
        drive(1, 1, 4'hF, 4'd7, 32'hAAAAAAAA, 1, 1, 4'h3, 4'd7, 32'hBBBBBBBB);
        drive(1, 1, 4'h3, 4'd8, 32'hAAAAAAAA, 1, 1, 4'hC, 4'd8, 32'hBBBBBBBB);
        drive(1, 1, 4'h0, 4'd9, 32'h12345678, 1, 1, 4'h0, 4'd9, 32'h9ABCDEF0);
        drive(1, 1, 4'hF, 4'd10, 32'h0000CAFE, 1, 1, 4'hF, 4'd11, 32'h0000BEEF);
        drive(1, 1, 4'hF, 4'd12, 32'h5555AAAA, 1, 0, 4'hF, 4'd12, 32'h0);
        drive(1, 0, 4'h0, 4'd7, 32'h0, 1, 0, 4'h0, 4'd8, 32'h0);
        drive(1, 0, 4'h0, 4'd9, 32'h0, 1, 0, 4'h0, 4'd12, 32'h0);

        // Back-to-back reads 0..7
        for (int i = 0; i < 8; i++) drive(1, 0, 4'h0, 4'(i), 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
        idle(1);

        // Random traffic on a narrow address window to provoke collisions
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 3)), $urandom);
        end
        idle(3);

        // Reset mid-init with a read request held on A
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        repeat (6) drive(1, 0, 4'h0, 4'd3, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
        rst = 1'b1;
        drive(1, 0, 4'h0, 4'd3, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
        rst = 1'b0;
        wait_ready();
        chk_val("coll_cnt_after_reset", 32'(cnt1), 32'd0);

        // Reset on the cycle after a read: the two-cycle pipeline drops it
        drive(1, 0, 4'h0, 4'd2, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        wait_ready();
        drive(1, 0, 4'h0, 4'd8, 32'h0, 1, 0, 4'h0, 4'd7, 32'h0);
        idle(4);

        for (int i = 0; i < 4; i++) chk_val($sformatf("scoreboard_drained_%0d", i), 32'(sb[i].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
